// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 active-low matrix keypad front end for the calculator.
// Scans columns, debounces presses and releases, decodes keys into digits,
// operators and equals, and builds operand A, operand B and the operator
// code, with an equals level that falls only after the operands are stable.
//
// Handshake: key_valid is a one-cycle strobe with key_code valid in the same
// cycle; there is no ready, every strobe is consumed by the entry FSM.
//
// Optional feature: define KEYPAD_ENTRY_ERR_EN to add the entry_err output,
// a one-cycle pulse (the cycle after key_valid) for each rejected key.
module keypad_entry #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       ac,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] opt_a,
  output logic [3:0] opt_b,
  output logic [2:0] do_opt,
  output logic       equal_to,
  output logic       key_valid,
  output logic [3:0] key_code
`ifdef KEYPAD_ENTRY_ERR_EN
  ,
  output logic       entry_err
`endif
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CNT);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} scan_t;
  typedef enum logic [1:0] {E_A, E_B, E_DONE} entry_t;

  scan_t            scan_state, scan_next;
  entry_t           entry_state, entry_next;
  logic [3:0]       row_s1, row_s2;
  logic [1:0]       col_idx;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [3:0]       row_pat;
  logic             wait_clear;
  logic [1:0]       clear_streak;
  logic             div_done, deb_done, rows_idle, one_low;
  logic             is_digit, is_op, is_eq;
  logic [2:0]       op_code;
  logic [7:0]       acc_a, acc_b;
  logic [3:0]       a_nxt, b_nxt;
  logic [2:0]       op_nxt;
  logic             eq_accept;

  function automatic logic single_low(input logic [3:0] pat);
    case (pat)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] pat);
    case (pat)
      4'b1110: row_index = 2'd0;
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      default: row_index = 2'd3;
    endcase
  endfunction

  assign div_done  = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign deb_done  = (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1));
  assign rows_idle = (row_s2 == 4'hF);
  assign one_low   = single_low(row_s2);

  // Two-flop synchronizer for the asynchronous keypad rows.
  always_ff @(posedge clk or negedge ac) begin
    if (!ac) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  // Scanner state register.
  always_ff @(posedge clk or negedge ac) begin
    if (!ac) scan_state <= S_SCAN;
    else     scan_state <= scan_next;
  end

  // Scanner next state: a key held through reset is ignored until released.
  always_comb begin
    scan_next = scan_state;
    case (scan_state)
      S_SCAN:     if (div_done && one_low && !wait_clear) scan_next = S_DEBOUNCE;
      S_DEBOUNCE: if (row_s2 != row_pat) scan_next = S_SCAN;
                  else if (deb_done)     scan_next = S_PRESSED;
      S_PRESSED:  scan_next = S_RELEASE;
      S_RELEASE:  if (rows_idle && deb_done) scan_next = S_SCAN;
      default:    scan_next = S_SCAN;
    endcase
  end

  // Scanner outputs: one-hot active-low column drive and the key strobe.
  always_comb begin
    col_out   = ~(4'b0001 << col_idx);
    key_valid = (scan_state == S_PRESSED);
  end

  // Scanner datapath: dwell/debounce counters, column, latched key.
  // wait_clear needs four consecutive all-high samples (one full column
  // rotation) after reset before any press is accepted.
  always_ff @(posedge clk or negedge ac) begin
    if (!ac) begin
      col_idx      <= 2'd0;
      div_cnt      <= '0;
      deb_cnt      <= '0;
      row_pat      <= 4'hF;
      key_code     <= 4'd0;
      wait_clear   <= 1'b1;
      clear_streak <= 2'd0;
    end else begin
      case (scan_state)
        S_SCAN: begin
          if (div_done) begin
            div_cnt <= '0;
            if (wait_clear) begin
              if (!rows_idle)              clear_streak <= 2'd0;
              else if (clear_streak == 2'd3) wait_clear <= 1'b0;
              else                         clear_streak <= clear_streak + 2'd1;
            end
            if (one_low && !wait_clear) begin
              row_pat <= row_s2;
              deb_cnt <= '0;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_DEBOUNCE: begin
          if (row_s2 != row_pat) begin
            deb_cnt <= '0;
            div_cnt <= '0;
          end else if (deb_done) begin
            deb_cnt  <= '0;
            key_code <= {row_index(row_pat), col_idx};
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        S_PRESSED: deb_cnt <= '0;
        S_RELEASE: begin
          if (!rows_idle) begin
            deb_cnt <= '0;
          end else if (deb_done) begin
            deb_cnt <= '0;
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        default: deb_cnt <= '0;
      endcase
    end
  end

  // Key decode and 8-bit decimal accumulation.
  always_comb begin
    is_digit = (key_code <= 4'd9);
    is_eq    = (key_code == 4'd15);
    is_op    = !is_digit && !is_eq;
    op_code  = 3'(key_code - 4'd9);
    acc_a    = {4'd0, opt_a} * 8'd10 + {4'd0, key_code};
    acc_b    = {4'd0, opt_b} * 8'd10 + {4'd0, key_code};
  end

  // Entry state register.
  always_ff @(posedge clk or negedge ac) begin
    if (!ac) entry_state <= E_A;
    else     entry_state <= entry_next;
  end

  // Entry next state, advanced only on accepted keys.
  always_comb begin
    entry_next = entry_state;
    if (key_valid) begin
      case (entry_state)
        E_A:     if (is_op) entry_next = E_B;
        E_B:     if (is_eq) entry_next = E_DONE;
        E_DONE:  if (is_digit) entry_next = E_A;
                 else if (is_op) entry_next = E_B;
        default: entry_next = E_A;
      endcase
    end
  end

  // Entry outputs: next operand/operator values; overflowing digits are dropped.
  always_comb begin
    a_nxt     = opt_a;
    b_nxt     = opt_b;
    op_nxt    = do_opt;
    eq_accept = 1'b0;
    if (key_valid) begin
      case (entry_state)
        E_A: begin
          if (is_digit && acc_a <= 8'd15) a_nxt = acc_a[3:0];
          if (is_op) begin
            op_nxt = op_code;
            b_nxt  = 4'd0;
          end
        end
        E_B: begin
          if (is_digit && acc_b <= 8'd15) b_nxt = acc_b[3:0];
          if (is_op) op_nxt = op_code;
          if (is_eq) eq_accept = 1'b1;
        end
        E_DONE: begin
          if (is_digit) begin
            a_nxt  = key_code;
            b_nxt  = 4'd0;
            op_nxt = 3'd0;
          end else if (is_op) begin
            op_nxt = op_code;
            b_nxt  = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand registers and equals level; equals drops as the scanner leaves RELEASE.
  always_ff @(posedge clk or negedge ac) begin
    if (!ac) begin
      opt_a    <= 4'd0;
      opt_b    <= 4'd0;
      do_opt   <= 3'd0;
      equal_to <= 1'b0;
    end else begin
      opt_a  <= a_nxt;
      opt_b  <= b_nxt;
      do_opt <= op_nxt;
      if (eq_accept)
        equal_to <= 1'b1;
      else if (scan_state == S_RELEASE && scan_next == S_SCAN)
        equal_to <= 1'b0;
    end
  end

`ifdef KEYPAD_ENTRY_ERR_EN
  logic entry_reject;

  // Rejected key: operand overflow, or equals outside B entry.
  always_comb begin
    entry_reject = key_valid &&
                   ((is_digit && entry_state == E_A && acc_a > 8'd15) ||
                    (is_digit && entry_state == E_B && acc_b > 8'd15) ||
                    (is_eq && entry_state != E_B));
  end

  // Error pulse one cycle after the rejected key strobe.
  always_ff @(posedge clk or negedge ac) begin
    if (!ac) entry_err <= 1'b0;
    else     entry_err <= entry_reject;
  end
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Directed testbench for keypad_entry with a behavioural keypad model.
module tb_keypad_entry;

  logic       clk = 1'b0;
  logic       ac;
  logic [3:0] row_in;
  logic [3:0] col_out, opt_a, opt_b, key_code;
  logic [2:0] do_opt;
  logic       equal_to, key_valid;
`ifdef KEYPAD_ENTRY_ERR_EN
  logic       entry_err;
`endif

  // keypad model: pressed rows pull low only while their column is driven
  logic       key_down = 1'b0;
  logic [3:0] key_row_mask = 4'd0;
  logic [1:0] key_col = 2'd0;
  assign row_in = (key_down && !col_out[key_col]) ? ~key_row_mask : 4'hF;

  int compared = 0;
  int mismatched = 0;
  int kv_count = 0;
  int eq_cycles = 0;
  int err_count = 0;

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(4)) dut (
    .clk(clk), .ac(ac), .row_in(row_in), .col_out(col_out),
    .opt_a(opt_a), .opt_b(opt_b), .do_opt(do_opt), .equal_to(equal_to),
    .key_valid(key_valid), .key_code(key_code)
`ifdef KEYPAD_ENTRY_ERR_EN
    , .entry_err(entry_err)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // monitor: counts strobes, equals-high cycles and error pulses
  always @(posedge clk) begin
    if (key_valid) kv_count <= kv_count + 1;
    if (equal_to) eq_cycles <= eq_cycles + 1;
`ifdef KEYPAD_ENTRY_ERR_EN
    if (entry_err) err_count <= err_count + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press_down(input logic [1:0] r, input logic [1:0] c, input string tag);
    int kv0;
    int n;
    kv0 = kv_count;
    n = 0;
    key_row_mask = 4'b0001 << r;
    key_col = c;
    key_down = 1'b1;
    while (kv_count == kv0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_strobe_seen"}, (kv_count != kv0), 1);
  endtask

  task automatic tap(input logic [1:0] r, input logic [1:0] c, input string tag);
    int kv0;
    kv0 = kv_count;
    press_down(r, c, tag);
    repeat (12) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    check({tag, "_one_strobe"}, kv_count - kv0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_out"}, col_out, 4'b1110);
    check({tag, "_opt_a"}, opt_a, 0);
    check({tag, "_opt_b"}, opt_b, 0);
    check({tag, "_do_opt"}, do_opt, 0);
    check({tag, "_equal_to"}, equal_to, 0);
    check({tag, "_key_valid"}, key_valid, 0);
    check({tag, "_key_code"}, key_code, 0);
  endtask

  initial begin
    int kv0;
    int eq0;
    int err0;
    logic [3:0] c0;

    // reset and idle rotation
    ac = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
`ifdef KEYPAD_ENTRY_ERR_EN
    check("reset_entry_err", entry_err, 0);
`endif
    ac = 1'b1;
    repeat (4) @(posedge clk); @(negedge clk);
    check("rot_col1", col_out, 4'b1101);
    repeat (4) @(posedge clk); @(negedge clk);
    check("rot_col2", col_out, 4'b1011);
    repeat (4) @(posedge clk); @(negedge clk);
    check("rot_col3", col_out, 4'b0111);
    repeat (4) @(posedge clk); @(negedge clk);
    check("rot_col0", col_out, 4'b1110);

    // entry sequence 1 2 A 3 F
    tap(2'd0, 2'd1, "k1");
    check("k1_code", key_code, 1);
    check("k1_opt_a", opt_a, 1);
    tap(2'd0, 2'd2, "k2");
    check("k2_code", key_code, 2);
    check("k2_opt_a", opt_a, 12);
    tap(2'd2, 2'd2, "kA");
    check("kA_code", key_code, 10);
    check("kA_opt_a", opt_a, 12);
    check("kA_do_opt", do_opt, 1);
    check("kA_opt_b", opt_b, 0);
    tap(2'd0, 2'd3, "k3");
    check("k3_opt_b", opt_b, 3);
    kv0 = kv_count;
    press_down(2'd3, 2'd3, "kF");
    check("kF_eq_rise", equal_to, 1);
    repeat (12) @(negedge clk);
    check("kF_eq_held", equal_to, 1);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    check("kF_eq_fall", equal_to, 0);
    check("kF_one_strobe", kv_count - kv0, 1);
    check("kF_code", key_code, 15);
    check("kF_opt_a", opt_a, 12);
    check("kF_opt_b", opt_b, 3);
    check("kF_do_opt", do_opt, 1);

    // bounce on column 1, then a clean hold; digit in DONE restarts A
    kv0 = kv_count;
    key_row_mask = 4'b0001;
    key_col = 2'd1;
    for (int n = 0; n < 40 && col_out != 4'b1101; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      key_down = 1'b1;
      repeat (2) @(negedge clk);
      key_down = 1'b0;
      repeat (2) @(negedge clk);
    end
    press_down(2'd0, 2'd1, "bounce");
    repeat (12) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    check("bounce_one_strobe", kv_count - kv0, 1);
    check("bounce_code", key_code, 1);
    check("bounce_opt_a", opt_a, 1);
    check("bounce_opt_b", opt_b, 0);
    check("bounce_do_opt", do_opt, 0);

    // ghost: two rows low on column 0
    kv0 = kv_count;
    key_row_mask = 4'b0101;
    key_col = 2'd0;
    key_down = 1'b1;
    repeat (60) @(negedge clk);
    check("ghost_no_strobe", kv_count - kv0, 0);
    c0 = col_out;
    repeat (4) @(negedge clk);
    check("ghost_scan_moves", (col_out != c0), 1);
    key_down = 1'b0;
    repeat (30) @(negedge clk);

    // reset while the key is held in RELEASE
    press_down(2'd0, 2'd1, "midrst");
    repeat (3) @(negedge clk);
    check("midrst_opt_a_before", opt_a, 11);
    #2 ac = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    ac = 1'b1;
    kv0 = kv_count;
    repeat (80) @(negedge clk);
    check("midrst_held_no_strobe", kv_count - kv0, 0);
    key_down = 1'b0;
    repeat (40) @(negedge clk);
    tap(2'd0, 2'd1, "repress");
    check("repress_opt_a", opt_a, 1);

    // overflow and equals rejected in A entry
    err0 = err_count;
    tap(2'd1, 2'd2, "k6");
    check("k6_code", key_code, 6);
    check("k6_opt_a_kept", opt_a, 1);
`ifdef KEYPAD_ENTRY_ERR_EN
    check("k6_err_pulse", err_count - err0, 1);
`endif
    eq0 = eq_cycles;
    tap(2'd3, 2'd3, "kF_in_A");
    check("kF_in_A_no_equal", eq_cycles - eq0, 0);
    check("kF_in_A_opt_a", opt_a, 1);
    check("kF_in_A_do_opt", do_opt, 0);
`ifdef KEYPAD_ENTRY_ERR_EN
    check("kF_in_A_err_pulse", err_count - err0, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
